gpio_pad_ctrl: RTL and testbench

//  Core-side controller for the chip pad ring: owns every per-pad control (out/oe/cs/sl/ie/pu/pd)

---
 rtl/gpio_pad_pkg.sv | 46 ++++
 rtl/pad_sync.sv | 25 ++
 rtl/gpio_pad_ctrl.sv | 165 ++++++++++++++++
 tb/tb_gpio_pad_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pad_pkg.sv
// rtl/gpio_pad_pkg.sv - shared constants, config record and helpers for gpio_pad_ctrl
package gpio_pad_pkg;

  localparam logic [7:0] ADDR_INPUT_BASE  = 8'h40;
  localparam logic [7:0] ADDR_BIDIR_IN_LO = 8'h50;
  localparam logic [7:0] ADDR_BIDIR_IN_HI = 8'h51;
  localparam logic [7:0] ADDR_INPUT_IN    = 8'h52;
  localparam logic [7:0] ADDR_RISE_LO     = 8'h54;
  localparam logic [7:0] ADDR_RISE_HI     = 8'h55;

  localparam int CFG_OUT = 0;
  localparam int CFG_OE  = 1;
  localparam int CFG_CS  = 2;
  localparam int CFG_SL  = 3;
  localparam int CFG_IE  = 4;
  localparam int CFG_PU  = 5;
  localparam int CFG_PD  = 6;

  typedef struct packed {
    logic pd;
    logic pu;
    logic ie;
    logic sl;
    logic cs;
    logic oe;
    logic out;
  } bidir_cfg_t;

  localparam bidir_cfg_t BIDIR_CFG_RESET = '{pd: 1'b0, pu: 1'b0, ie: 1'b1, sl: 1'b0,
                                             cs: 1'b0, oe: 1'b0, out: 1'b0};

  typedef enum logic {ST_IDLE, ST_RESP} bus_state_t;

  // Pull-up takes priority so a pad is never driven both ways.
  function automatic bidir_cfg_t to_bidir_cfg(input logic [6:0] w);
    logic [6:0] v;
    v = w;
    if (v[CFG_PU]) v[CFG_PD] = 1'b0;
    return bidir_cfg_t'(v);
  endfunction

  function automatic logic [1:0] to_input_cfg(input logic [1:0] w);
    return {w[1] & ~w[0], w[0]};
  endfunction

endpackage

// File: rtl/pad_sync.sv
// rtl/pad_sync.sv - multi-flop synchroniser for asynchronous pad inputs
module pad_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/gpio_pad_ctrl.sv
// rtl/gpio_pad_ctrl.sv - pad ring controller: config registers, input sync, rise status, irq
module gpio_pad_ctrl
  import gpio_pad_pkg::*;
#(
  parameter int NUM_INPUT_PADS = 12,
  parameter int NUM_BIDIR_PADS = 40,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [7:0]                req_addr,
  input  logic [31:0]               req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_err,
  output logic                      irq,
  input  logic [NUM_INPUT_PADS-1:0] input_in,
  output logic [NUM_INPUT_PADS-1:0] input_pu,
  output logic [NUM_INPUT_PADS-1:0] input_pd,
  input  logic [NUM_BIDIR_PADS-1:0] bidir_in,
  output logic [NUM_BIDIR_PADS-1:0] bidir_out,
  output logic [NUM_BIDIR_PADS-1:0] bidir_oe,
  output logic [NUM_BIDIR_PADS-1:0] bidir_cs,
  output logic [NUM_BIDIR_PADS-1:0] bidir_sl,
  output logic [NUM_BIDIR_PADS-1:0] bidir_ie,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pu,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pd
);

  localparam int BLANK_CYCLES = SYNC_STAGES + 1;
  localparam int BLANK_W      = $clog2(BLANK_CYCLES + 1);

  bus_state_t                state;
  bidir_cfg_t                bidir_cfg [NUM_BIDIR_PADS];
  logic [1:0]                input_cfg [NUM_INPUT_PADS];
  logic [NUM_INPUT_PADS-1:0] input_sync;
  logic [NUM_BIDIR_PADS-1:0] bidir_sync, bidir_prev, rise, rise_next;
  logic [63:0]               bidir_sync_w, rise_w, w1c_mask;
  logic [31:0]               input_sync_w, rd_data;
  logic [BLANK_W-1:0]        blank_cnt;
  logic                      acc_err, accept, do_write;

  pad_sync #(.WIDTH(NUM_INPUT_PADS), .STAGES(SYNC_STAGES)) u_input_sync (
    .clk(clk), .rst(rst), .d(input_in), .q(input_sync)
  );

  pad_sync #(.WIDTH(NUM_BIDIR_PADS), .STAGES(SYNC_STAGES)) u_bidir_sync (
    .clk(clk), .rst(rst), .d(bidir_in), .q(bidir_sync)
  );

  assign req_ready = !rsp_valid;
  assign accept    = req_valid && req_ready;
  assign do_write  = accept && req_write && !acc_err;

  always_comb begin
    bidir_sync_w = '0;
    rise_w       = '0;
    input_sync_w = '0;
    bidir_sync_w[NUM_BIDIR_PADS-1:0] = bidir_sync;
    rise_w[NUM_BIDIR_PADS-1:0]       = rise;
    input_sync_w[NUM_INPUT_PADS-1:0] = input_sync;
  end

  always_comb begin
    rd_data = '0;
    acc_err = 1'b0;
    if (req_addr < ADDR_INPUT_BASE) begin
      if (int'(req_addr) < NUM_BIDIR_PADS) begin
        for (int i = 0; i < NUM_BIDIR_PADS; i++)
          if (req_addr[5:0] == 6'(i)) rd_data = 32'(bidir_cfg[i]);
      end else begin
        acc_err = 1'b1;
      end
    end else if (req_addr[7:4] == 4'h4) begin
      if (int'(req_addr[3:0]) < NUM_INPUT_PADS) begin
        for (int i = 0; i < NUM_INPUT_PADS; i++)
          if (req_addr[3:0] == 4'(i)) rd_data = 32'(input_cfg[i]);
      end else begin
        acc_err = 1'b1;
      end
    end else begin
      case (req_addr)
        ADDR_BIDIR_IN_LO: begin rd_data = bidir_sync_w[31:0];  acc_err = req_write; end
        ADDR_BIDIR_IN_HI: begin rd_data = bidir_sync_w[63:32]; acc_err = req_write; end
        ADDR_INPUT_IN:    begin rd_data = input_sync_w;        acc_err = req_write; end
        ADDR_RISE_LO:     rd_data = rise_w[31:0];
        ADDR_RISE_HI:     rd_data = rise_w[63:32];
        default:          acc_err = 1'b1;
      endcase
    end
  end

  // A fresh edge in the same cycle as a W1C keeps the bit set.
  always_comb begin
    w1c_mask = '0;
    if (do_write && req_addr == ADDR_RISE_LO) w1c_mask[31:0]  = req_wdata;
    if (do_write && req_addr == ADDR_RISE_HI) w1c_mask[63:32] = req_wdata;
    rise_next = rise & ~w1c_mask[NUM_BIDIR_PADS-1:0];
    if (blank_cnt == BLANK_W'(BLANK_CYCLES)) rise_next = rise_next | (bidir_sync & ~bidir_prev);
  end

  always_comb begin
    for (int i = 0; i < NUM_BIDIR_PADS; i++) begin
      bidir_out[i] = bidir_cfg[i][CFG_OUT];
      bidir_oe[i]  = bidir_cfg[i][CFG_OE];
      bidir_cs[i]  = bidir_cfg[i][CFG_CS];
      bidir_sl[i]  = bidir_cfg[i][CFG_SL];
      bidir_ie[i]  = bidir_cfg[i][CFG_IE];
      bidir_pu[i]  = bidir_cfg[i][CFG_PU];
      bidir_pd[i]  = bidir_cfg[i][CFG_PD];
    end
    for (int i = 0; i < NUM_INPUT_PADS; i++) begin
      input_pu[i] = input_cfg[i][0];
      input_pd[i] = input_cfg[i][1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      irq        <= 1'b0;
      rise       <= '0;
      bidir_prev <= '0;
      blank_cnt  <= '0;
      for (int i = 0; i < NUM_BIDIR_PADS; i++) bidir_cfg[i] <= BIDIR_CFG_RESET;
      for (int i = 0; i < NUM_INPUT_PADS; i++) input_cfg[i] <= '0;
    end else begin
      bidir_prev <= bidir_sync;
      rise       <= rise_next;
      irq        <= |rise;
      if (blank_cnt != BLANK_W'(BLANK_CYCLES)) blank_cnt <= blank_cnt + 1'b1;
      if (do_write) begin
        for (int i = 0; i < NUM_BIDIR_PADS; i++)
          if (req_addr < ADDR_INPUT_BASE && req_addr[5:0] == 6'(i))
            bidir_cfg[i] <= to_bidir_cfg(req_wdata[6:0]);
        for (int i = 0; i < NUM_INPUT_PADS; i++)
          if (req_addr[7:4] == 4'h4 && req_addr[3:0] == 4'(i))
            input_cfg[i] <= to_input_cfg(req_wdata[1:0]);
      end
      case (state)
        ST_IDLE: if (accept) begin
          state     <= ST_RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= acc_err;
          rsp_rdata <= (acc_err || req_write) ? '0 : rd_data;
        end
        ST_RESP: if (rsp_ready) begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// tb/tb_gpio_pad_ctrl.sv - self-checking bench for gpio_pad_ctrl
module tb_gpio_pad_ctrl;

  localparam int NI = 12;
  localparam int NB = 40;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [7:0]    req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid, rsp_ready = 1'b1, rsp_err, irq;
  logic [31:0]   rsp_rdata;
  logic [NI-1:0] input_in = '1, input_pu, input_pd;
  logic [NB-1:0] bidir_in = 40'h00_A5A5_5A5A;
  logic [NB-1:0] bidir_out, bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd;

  gpio_pad_ctrl #(.NUM_INPUT_PADS(NI), .NUM_BIDIR_PADS(NB), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .irq(irq),
    .input_in(input_in), .input_pu(input_pu), .input_pd(input_pd),
    .bidir_in(bidir_in), .bidir_out(bidir_out), .bidir_oe(bidir_oe), .bidir_cs(bidir_cs),
    .bidir_sl(bidir_sl), .bidir_ie(bidir_ie), .bidir_pu(bidir_pu), .bidir_pd(bidir_pd)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [6:0]   cfg_m [64];
  logic [1:0]   inc_m [32];
  logic [63:0]  st_m;
  logic [303:0] snap;

  typedef struct {
    logic        w;
    logic [7:0]  a;
    logic [31:0] d;
    logic [31:0] er;
    logic        ee;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [303:0] dut_pads();
    return {bidir_pd, bidir_pu, bidir_ie, bidir_sl, bidir_cs, bidir_oe, bidir_out, input_pd, input_pu};
  endfunction

  function automatic logic [303:0] exp_pads();
    logic [NB-1:0] v [7];
    logic [NI-1:0] ipu, ipd;
    for (int b = 0; b < 7; b++)
      for (int i = 0; i < NB; i++) v[b][i] = cfg_m[i][b];
    for (int i = 0; i < NI; i++) begin
      ipu[i] = inc_m[i][0];
      ipd[i] = inc_m[i][1];
    end
    return {v[6], v[5], v[4], v[3], v[2], v[1], v[0], ipd, ipu};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) cfg_m[i] = 7'h10;
    for (int i = 0; i < 32; i++) inc_m[i] = 2'b00;
    st_m = '0;
  endtask

  // Register map behaviour; pad reads assume pads have been stable for a while.
  task automatic model(input logic w, input logic [7:0] a, input logic [31:0] d,
                       output logic [31:0] r, output logic e);
    logic [6:0]  v;
    logic [63:0] pads;
    int          idx;
    r = '0;
    e = 1'b0;
    pads = 64'(bidir_in);
    if (a < 8'h40) begin
      idx = int'(a);
      if (idx < NB) begin
        if (w) begin
          v = d[6:0];
          if (v[5] && v[6]) v[6] = 1'b0;
          cfg_m[idx] = v;
        end else r = 32'(cfg_m[idx]);
      end else e = 1'b1;
    end else if (a < 8'h50) begin
      idx = int'(a) - 64;
      if (idx < NI) begin
        if (w) inc_m[idx] = (d[1:0] == 2'b11) ? 2'b01 : d[1:0];
        else   r = 32'(inc_m[idx]);
      end else e = 1'b1;
    end else if (a == 8'h50 || a == 8'h51 || a == 8'h52) begin
      if (w) e = 1'b1;
      else if (a == 8'h50) r = pads[31:0];
      else if (a == 8'h51) r = pads[63:32];
      else r = 32'(input_in);
    end else if (a == 8'h54 || a == 8'h55) begin
      if (w) st_m = st_m & ~((a == 8'h54) ? {32'h0, d} : {d, 32'h0});
      else   r = (a == 8'h54) ? st_m[31:0] : st_m[63:32];
    end else e = 1'b1;
  endtask

  task automatic txn(input logic w, input logic [7:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic e);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; rsp_ready = 1'b1;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("accept_timeout", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rsp_latency", rsp_valid, 1);
    rd   = rsp_rdata;
    e    = rsp_err;
    snap = dut_pads();
    @(negedge clk);
    chk("rsp_release", rsp_valid, 0);
  endtask

  task automatic run_model(input string name, input logic w, input logic [7:0] a, input logic [31:0] d);
    logic [31:0] mr, rd;
    logic        me, e;
    model(w, a, d, mr, me);
    txn(w, a, d, rd, e);
    chk({name, "_rdata"}, rd, mr);
    chk({name, "_err"}, e, me);
    chk({name, "_pads"}, snap, exp_pads());
    chk({name, "_irq"}, irq, |st_m);
  endtask

  task automatic pad_step();
    logic [63:0]   r;
    logic [NB-1:0] nb;
    r  = {$urandom, $urandom};
    nb = r[NB-1:0];
    st_m = st_m | 64'(nb & ~bidir_in);
    bidir_in = nb;
    input_in = NI'($urandom);
    repeat (SS + 3) @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd, mr, hold_rd;
    logic        e, me;
    logic [7:0]  a;

    tbl[0]  = '{1'b1, 8'h05, 32'h03,       32'h0,       1'b0};
    tbl[1]  = '{1'b0, 8'h05, 32'h0,        32'h03,      1'b0};
    tbl[2]  = '{1'b0, 8'h10, 32'h0,        32'h10,      1'b0};
    tbl[3]  = '{1'b1, 8'h41, 32'h3,        32'h0,       1'b0};
    tbl[4]  = '{1'b0, 8'h41, 32'h0,        32'h1,       1'b0};
    tbl[5]  = '{1'b1, 8'h28, 32'h1,        32'h0,       1'b1};
    tbl[6]  = '{1'b0, 8'h28, 32'h0,        32'h0,       1'b1};
    tbl[7]  = '{1'b1, 8'h50, 32'h0,        32'h0,       1'b1};
    tbl[8]  = '{1'b0, 8'h60, 32'h0,        32'h0,       1'b1};
    tbl[9]  = '{1'b0, 8'h4C, 32'h0,        32'h0,       1'b1};
    tbl[10] = '{1'b0, 8'h53, 32'h0,        32'h0,       1'b1};
    tbl[11] = '{1'b1, 8'h00, 32'hFFFFFFFF, 32'h0,       1'b0};
    tbl[12] = '{1'b0, 8'h00, 32'h0,        32'h3F,      1'b0};
    tbl[13] = '{1'b1, 8'h27, 32'h42,       32'h0,       1'b0};
    tbl[14] = '{1'b0, 8'h27, 32'h0,        32'h42,      1'b0};
    tbl[15] = '{1'b1, 8'h4B, 32'h2,        32'h0,       1'b0};
    tbl[16] = '{1'b0, 8'h4B, 32'h0,        32'h2,       1'b0};
    tbl[17] = '{1'b0, 8'h52, 32'h0,        32'hFFF,     1'b0};
    tbl[18] = '{1'b0, 8'h50, 32'h0,        32'hA5A55A5A, 1'b0};
    tbl[19] = '{1'b0, 8'h54, 32'h0,        32'h0,       1'b0};

    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", req_ready, 1);
    chk("reset_irq", irq, 0);
    chk("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
    chk("reset_pads", dut_pads(), exp_pads());
    repeat (SS + 4) @(negedge clk);
    chk("blank_irq", irq, 0);

    for (int k = 0; k < 20; k++) begin
      txn(tbl[k].w, tbl[k].a, tbl[k].d, rd, e);
      model(tbl[k].w, tbl[k].a, tbl[k].d, mr, me);
      chk($sformatf("tbl%0d_rdata", k), rd, tbl[k].er);
      chk($sformatf("tbl%0d_err", k), e, tbl[k].ee);
      chk($sformatf("tbl%0d_pads", k), snap, exp_pads());
      chk($sformatf("tbl%0d_irq", k), irq, 0);
    end

    bidir_in[33] = 1'b1;
    st_m[33] = 1'b1;
    repeat (3) @(negedge clk);
    chk("edge_irq_early", irq, 0);
    @(negedge clk);
    chk("edge_irq_set", irq, 1);
    txn(1'b0, 8'h55, 32'h0, rd, e);
    chk("rise_hi_rdata", rd, 32'h2);
    run_model("rise_hi_w1c", 1'b1, 8'h55, 32'h2);

    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h07; rsp_ready = 1'b0;
    @(negedge clk);
    chk("stall_rsp_valid", rsp_valid, 1);
    chk("stall_rdata", rsp_rdata, 32'(cfg_m[7]));
    hold_rd = rsp_rdata;
    req_write = 1'b1; req_wdata = 32'h7F;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stall_req_ready", req_ready, 0);
      chk("stall_hold", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, hold_rd});
      chk("stall_no_accept", bidir_oe[7], cfg_m[7][1]);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    chk("stall_release", rsp_valid, 0);
    run_model("stall_readback", 1'b0, 8'h07, 32'h0);

    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 4) == 0) pad_step();
      else begin
        case ($urandom_range(0, 3))
          0:       a = 8'($urandom_range(0, 63));
          1:       a = 8'h40 + 8'($urandom_range(0, 15));
          2:       a = 8'h50 + 8'($urandom_range(0, 7));
          default: a = 8'($urandom_range(0, 255));
        endcase
        run_model($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)), a, $urandom);
      end
    end

    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h05; req_wdata = 32'h7F; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    model_reset();
    @(negedge clk);
    chk("midrst_rsp", rsp_valid, 0);
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_pads", dut_pads(), exp_pads());
    chk("midrst_irq", irq, 0);
    repeat (SS + 4) @(negedge clk);
    run_model("midrst_rise_lo", 1'b0, 8'h54, 32'h0);
    run_model("midrst_rise_hi", 1'b0, 8'h55, 32'h0);
    model(1'b0, 8'h05, 32'h0, mr, me);
    txn(1'b0, 8'h05, 32'h0, rd, e);
    chk("midrst_cfg5", rd, mr);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
